// File: rtl/zero_detect_frame_counter.sv
// Frame statistics stage behind the Mealy zero detector.
// Counts detections and longest detection run per frame, one-entry output register.
module zero_detect_frame_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W-1:0] run_max,
  output logic             ovf_out,
  output logic             frame_drop
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [7:0]       LAST = 8'(FRAME_LEN - 1);

  logic [0:0]       state;
  logic [7:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] run_cur;
  logic [CNT_W-1:0] run_best;
  logic             ovf_acc;

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] run_nxt;
  logic [CNT_W-1:0] best_nxt;
  logic             ovf_nxt;
  logic             frame_end;
  logic             load;
  logic             drop;

  // Next accumulator values include the current bit, so a frame end
  // can publish them directly while the accumulators clear.
  always_comb begin
    cnt_nxt  = cnt;
    run_nxt  = run_cur;
    ovf_nxt  = ovf_acc;
    if (y_in) begin
      if (cnt == SAT) ovf_nxt = 1'b1;
      else            cnt_nxt = cnt + 1'b1;
      if (run_cur == SAT) ovf_nxt = 1'b1;
      else                run_nxt = run_cur + 1'b1;
    end else begin
      run_nxt = '0;
    end
    best_nxt = (run_nxt > run_best) ? run_nxt : run_best;
  end

  assign frame_end = bit_valid && (bit_idx == LAST);
  assign load      = frame_end && ((state == EMPTY) || out_ready);
  assign drop      = frame_end && (state == FULL) && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx  <= '0;
      cnt      <= '0;
      run_cur  <= '0;
      run_best <= '0;
      ovf_acc  <= 1'b0;
    end else if (frame_end) begin
      bit_idx  <= '0;
      cnt      <= '0;
      run_cur  <= '0;
      run_best <= '0;
      ovf_acc  <= 1'b0;
    end else if (bit_valid) begin
      bit_idx  <= bit_idx + 8'd1;
      cnt      <= cnt_nxt;
      run_cur  <= run_nxt;
      run_best <= best_nxt;
      ovf_acc  <= ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      count_out  <= '0;
      run_max    <= '0;
      ovf_out    <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= drop;
      if (load) begin
        state     <= FULL;
        count_out <= cnt_nxt;
        run_max   <= best_nxt;
        ovf_out   <= ovf_nxt;
      end else if ((state == FULL) && out_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_zero_detect_frame_counter.sv
// Bench for zero_detect_frame_counter: directed plan steps plus random traffic
// against a frame-level reference model, for CNT_W=4 and CNT_W=2 instances.
module tb_zero_detect_frame_counter;

  localparam int FL = 8;

  logic clk = 1'b0;
  logic reset, y_in, bit_valid, out_ready;

  logic       v1, v2, d1, d2, o1, o2;
  logic [3:0] c1, r1;
  logic [1:0] c2, r2;

  int tests = 0;
  int fails = 0;

  bit frame[$];
  int ev, ed;
  int ec1, er1, eo1;
  int ec2, er2, eo2;

  zero_detect_frame_counter #(.FRAME_LEN(FL), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .y_in(y_in), .bit_valid(bit_valid),
    .out_ready(out_ready), .out_valid(v1), .count_out(c1),
    .run_max(r1), .ovf_out(o1), .frame_drop(d1)
  );

  zero_detect_frame_counter #(.FRAME_LEN(FL), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .y_in(y_in), .bit_valid(bit_valid),
    .out_ready(out_ready), .out_valid(v2), .count_out(c2),
    .run_max(r2), .ovf_out(o2), .frame_drop(d2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame statistics from the whole bit list: totals and longest run,
  // clipped at maxv; overflow whenever either raw value exceeds maxv.
  function automatic void calc(input bit b[$], input int maxv,
                               output int c, output int r, output int o);
    int sum, best, cur;
    sum = 0; best = 0; cur = 0;
    foreach (b[i]) begin
      if (b[i]) begin
        sum++;
        cur++;
        if (cur > best) best = cur;
      end else cur = 0;
    end
    c = (sum > maxv) ? maxv : sum;
    r = (best > maxv) ? maxv : best;
    o = (sum > maxv || best > maxv) ? 1 : 0;
  endfunction

  task automatic step(input bit rst, input bit bv, input bit y, input bit rdy);
    reset = rst; bit_valid = bv; y_in = y; out_ready = rdy;
    @(posedge clk);
    #1;
    ed = 0;
    if (rst) begin
      frame.delete();
      ev = 0;
      ec1 = 0; er1 = 0; eo1 = 0;
      ec2 = 0; er2 = 0; eo2 = 0;
    end else begin
      if (bv) frame.push_back(y);
      if (bv && frame.size() == FL) begin
        if (ev == 0 || rdy) begin
          ev = 1;
          calc(frame, 15, ec1, er1, eo1);
          calc(frame, 3, ec2, er2, eo2);
        end else ed = 1;
        frame.delete();
      end else if (ev == 1 && rdy) ev = 0;
    end
    chk("valid1", v1, ev);
    chk("drop1", d1, ed);
    chk("valid2", v2, ev);
    chk("drop2", d2, ed);
    if (ev == 1 || rst) begin
      chk("count1", c1, ec1);
      chk("run1", r1, er1);
      chk("ovf1", o1, eo1);
      chk("count2", c2, ec2);
      chk("run2", r2, er2);
      chk("ovf2", o2, eo2);
    end
  endtask

  task automatic frame_bits(input logic [7:0] pat, input bit rdy_last,
                            input bit rdy_rest);
    for (int i = 7; i >= 0; i--)
      step(0, 1, pat[i], (i == 0) ? rdy_last : rdy_rest);
  endtask

  initial begin
    logic [7:0] p;
    ev = 0; ed = 0;
    reset = 1; bit_valid = 0; y_in = 0; out_ready = 0;

    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    chk("rst_count", c1, 0);
    chk("rst_valid", v1, 0);

    p = 8'b11011100;
    frame_bits(p, 1, 1);
    chk("p1_count", c1, 5);
    chk("p1_run", r1, 3);
    chk("p1_ovf", o1, 0);
    step(0, 0, 0, 1);
    chk("p1_pop", v1, 0);

    for (int i = 7; i >= 0; i--) begin
      step(0, 1, p[i], 1);
      if (i != 0) step(0, 0, 1, 1);
    end
    chk("gap_count", c1, 5);
    chk("gap_run", r1, 3);
    step(0, 0, 1, 1);

    frame_bits(8'h00, 0, 0);
    frame_bits(8'hFF, 0, 0);
    chk("bp_drop", d1, 1);
    chk("bp_held", c1, 0);
    step(0, 0, 0, 0);
    chk("bp_drop_once", d1, 0);
    step(0, 0, 0, 1);

    frame_bits(8'h0F, 0, 0);
    frame_bits(8'hFF, 1, 0);
    chk("simul_valid", v1, 1);
    chk("simul_count", c1, 8);
    chk("simul_drop", d1, 0);
    chk("w2_count", c2, 3);
    chk("w2_run", r2, 3);
    chk("w2_ovf", o2, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 5; i++) step(0, 1, 1, 1);
    step(1, 0, 0, 1);
    chk("mid_rst_valid", v1, 0);
    frame_bits(8'b10101010, 1, 1);
    chk("alt_count", c1, 4);
    chk("alt_run", r1, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 2) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
